// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage MIPS pipeline. It detects load-use
//   hazards, squashes wrong-path instructions when a branch resolves taken in
//   MEM, and freezes the pipeline while data memory holds off an access.
//   A dmem wait longer than MEM_TIMEOUT cycles locks the sequencer in FAULT
//   until reset.
//
// Parameters
//   MEM_TIMEOUT  max consecutive dmem wait cycles before fault (>=1)
//   CNT_W        width of the wait counter, must hold MEM_TIMEOUT
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   id_rs, id_rt            source registers of the instruction in ID
//   id_uses_rt              ID instruction reads rt
//   ex_memread, ex_rt       load in EX and its destination register
//   mem_branch_taken        branch resolved taken in MEM
//   mem_access, dmem_ready  MEM-stage memory access and its completion
//   pc_en, *_en, *_flush    PC and pipeline-register enables / bubble loads
//   mem_fault               sticky dmem timeout flag
//
// Configuration
//   HAZARD_PERF_EN  adds stall_cycles / flush_events performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        mem_branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_en,
    output logic        ex_mem_flush,
    output logic        mem_wb_en,
    output logic        mem_wb_flush,
    output logic        mem_fault
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             w_load_use;
    logic             w_dmem_wait;
    logic             w_branch_flush;

    // $0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_load_use = ex_memread && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // In WAIT the access is still pending, so only dmem_ready matters there.
    assign w_dmem_wait = ((r_state == ST_RUN) && mem_access && !dmem_ready) ||
                         ((r_state == ST_WAIT) && !dmem_ready);

    assign mem_fault = (r_state == ST_FAULT);

    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_en       = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_en      = 1'b1;
        ex_mem_flush   = 1'b0;
        mem_wb_en      = 1'b1;
        mem_wb_flush   = 1'b0;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_branch_flush = 1'b0;

        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (r_state == ST_FAULT) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_dmem_wait) begin
            // Freeze: the access in MEM stays put, WB receives a bubble.
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            id_ex_en       = 1'b0;
            ex_mem_en      = 1'b0;
            mem_wb_flush   = 1'b1;
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = (r_state == ST_RUN) ? CNT_ONE : r_wait_cnt + CNT_ONE;
            if ((r_state == ST_WAIT) && (r_wait_cnt == TIMEOUT_C)) begin
                w_state_nxt = ST_FAULT;
            end
        end else begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
            if (mem_branch_taken) begin
                // Branch wins over load-use: the stalled instruction is squashed.
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                ex_mem_flush   = 1'b1;
                w_branch_flush = 1'b1;
            end else if (w_load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (r_state != ST_FAULT) begin
            if (!pc_en) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_branch_flush) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4. Inputs change
//   1ns after the rising edge, outputs are checked on the falling edge.
//   Output vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//   ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_memread;
    logic [4:0] ex_rt;
    logic       mem_branch_taken;
    logic       mem_access;
    logic       dmem_ready;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       ex_mem_flush;
    logic       mem_wb_en;
    logic       mem_wb_flush;
    logic       mem_fault;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [8:0] V_RUN     = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] V_RESET   = 9'b0_0_1_0_1_0_1_0_1;
    localparam logic [8:0] V_LOADUSE = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] V_BRANCH  = 9'b1_1_1_1_1_1_1_1_0;
    localparam logic [8:0] V_FREEZE  = 9'b0_0_0_0_0_0_0_1_1;
    localparam logic [8:0] V_FAULT   = 9'b0_0_0_0_0_0_0_0_0;

    logic [8:0] w_obs;
    assign w_obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                    ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread),
        .ex_rt(ex_rt),
        .mem_branch_taken(mem_branch_taken),
        .mem_access(mem_access),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en),
        .if_id_en(if_id_en),
        .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en),
        .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_en(mem_wb_en),
        .mem_wb_flush(mem_wb_flush),
        .mem_fault(mem_fault)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // mem_wb_en is left unconstrained during a freeze (mem_wb_flush decides).
    task automatic chk_freeze(input string tag);
        chk9(tag, w_obs | 9'b0_0_0_0_0_0_0_1_0, V_FREEZE);
    endtask

    task automatic set_in(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses, input logic mr, input logic [4:0] xrt,
                          input logic br, input logic acc, input logic rdy);
        rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_memread = mr;
        ex_rt = xrt; mem_branch_taken = br; mem_access = acc; dmem_ready = rdy;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset cycle
        set_in(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("reset_outputs", w_obs, V_RESET); nxt();

        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("idle_run", w_obs, V_RUN); chk1("fault_after_reset", mem_fault, 1'b0); nxt();

        // load-use on rs
        set_in(1, 5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 1);
        to_neg(); chk9("loaduse_rs", w_obs, V_LOADUSE); nxt();
        set_in(1, 5'd8, 5'd2, 0, 0, 5'd4, 0, 0, 1);
        to_neg(); chk9("after_loaduse", w_obs, V_RUN); nxt();

        // load-use on rt, then same regs with rt not read
        set_in(1, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0, 1);
        to_neg(); chk9("loaduse_rt", w_obs, V_LOADUSE); nxt();
        set_in(1, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0, 1);
        to_neg(); chk9("rt_not_used", w_obs, V_RUN); nxt();

        // $0 never stalls; non-load never stalls
        set_in(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 1);
        to_neg(); chk9("reg0_no_stall", w_obs, V_RUN); nxt();
        set_in(1, 5'd8, 5'd0, 0, 0, 5'd8, 0, 0, 1);
        to_neg(); chk9("no_memread", w_obs, V_RUN); nxt();

        // branch, and branch beating load-use
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1);
        to_neg(); chk9("branch", w_obs, V_BRANCH); nxt();
        set_in(1, 5'd7, 5'd0, 0, 1, 5'd7, 1, 0, 1);
        to_neg(); chk9("branch_over_loaduse", w_obs, V_BRANCH); nxt();
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("after_branch", w_obs, V_RUN); nxt();

        // dmem wait of 3 cycles; first cycle also has branch + load-use pending
        set_in(1, 5'd7, 5'd0, 0, 1, 5'd7, 1, 1, 0);
        to_neg(); chk_freeze("freeze_c1_priority"); nxt();
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        to_neg(); chk_freeze("freeze_c2"); nxt();
        to_neg(); chk_freeze("freeze_c3"); nxt();
        // release cycle applies normal decode
        set_in(1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 1, 1);
        to_neg(); chk9("release_loaduse", w_obs, V_LOADUSE); nxt();
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("after_release", w_obs, V_RUN); nxt();

        // timeout: 5 freeze cycles, FAULT after the 5th edge
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            to_neg();
            chk_freeze($sformatf("timeout_freeze_c%0d", i));
            chk1($sformatf("timeout_nofault_c%0d", i), mem_fault, 1'b0);
            nxt();
        end
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("fault_outputs", w_obs, V_FAULT); chk1("fault_flag", mem_fault, 1'b1); nxt();
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1);
        to_neg(); chk9("fault_ignores_branch", w_obs, V_FAULT); chk1("fault_sticky", mem_fault, 1'b1); nxt();

        set_in(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("reset_from_fault", w_obs, V_RESET); nxt();
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("run_after_fault_reset", w_obs, V_RUN); chk1("fault_cleared", mem_fault, 1'b0); nxt();

        // reset during WAIT
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        to_neg(); chk_freeze("wait_before_reset_c1"); nxt();
        to_neg(); chk_freeze("wait_before_reset_c2"); nxt();
        set_in(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        to_neg(); chk9("reset_mid_wait", w_obs, V_RESET); nxt();
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        to_neg(); chk9("run_after_wait_reset", w_obs, V_RUN); chk1("nofault_after_wait_reset", mem_fault, 1'b0); nxt();

        // one branch flush, one load-use stall for the counters
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1);
        to_neg(); chk9("branch_perf", w_obs, V_BRANCH); nxt();
        set_in(1, 5'd6, 5'd0, 0, 1, 5'd6, 0, 0, 1);
        to_neg(); chk9("loaduse_perf", w_obs, V_LOADUSE); nxt();
        set_in(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        to_neg(); chk9("final_run", w_obs, V_RUN);
`ifdef HAZARD_PERF_EN
        chk32("stall_cycles", stall_cycles, 32'd1);
        chk32("flush_events", flush_events, 32'd1);
`endif
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
